// File: rtl/video_timing_gen.sv
`timescale 1ns/1ps
// Raster timing generator: pixel enable, h/v counters, sync/blank/active decode, strobes, raster interrupt.
// Latency: decoded outputs are registered from next-state counters, so they align exactly with hcount/vcount.
// Backpressure: none; en=0 freezes the whole raster, sync_rst restarts it at (0,0) and overrides en.
module video_timing_gen #(
  parameter int   H_ACTIVE = 256,
  parameter int   H_FP     = 8,
  parameter int   H_SYNC   = 32,
  parameter int   H_BP     = 88,
  parameter int   V_ACTIVE = 240,
  parameter int   V_FP     = 3,
  parameter int   V_SYNC   = 3,
  parameter int   V_BP     = 16,
  parameter int   PIX_DIV  = 2,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   FW       = 8,
  localparam int  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  HW       = $clog2(H_TOTAL),
  localparam int  VW       = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic          en,
  input  logic          sync_rst,
  input  logic          vint_en,
  input  logic [VW-1:0] vint_line,
  input  logic          vint_ack,
  output logic          pix_ce,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          hblank,
  output logic          vblank,
  output logic          active,
  output logic          tile_load,
  output logic          line_start,
  output logic          frame_start,
  output logic          vint,
  output logic [FW-1:0] frame_cnt
);

  localparam int DW       = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

  // Reject degenerate timings at elaboration rather than producing a broken raster.
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      PIX_DIV < 1 || (H_ACTIVE % 8) != 0) begin : g_bad_cfg
    $error("video_timing_gen: illegal timing parameters");
  end

  logic [DW-1:0] div;
  logic [DW-1:0] div_nxt;
  logic [HW-1:0] hcount_nxt;
  logic [VW-1:0] vcount_nxt;
  logic          div_last;
  logic          h_last;
  logic          v_last;
  logic          wrap_h;
  logic          wrap_v;
  logic          hsync_nxt;
  logic          vsync_nxt;
  logic          hblank_nxt;
  logic          vblank_nxt;

  assign div_last  = (div == DIV_LAST);
  assign h_last    = (hcount == H_LAST);
  assign v_last    = (vcount == V_LAST);
  assign pix_ce    = en & div_last;
  assign wrap_h    = pix_ce & h_last;
  assign wrap_v    = wrap_h & v_last;
  assign tile_load = pix_ce & (hcount[2:0] == 3'b111);

  // Next counter values and their region decode, so registered outputs land with the counters.
  always_comb begin
    div_nxt    = div_last ? '0 : div + DW'(1);
    hcount_nxt = hcount;
    vcount_nxt = vcount;
    if (pix_ce) begin
      hcount_nxt = h_last ? '0 : hcount + HW'(1);
    end
    if (wrap_h) begin
      vcount_nxt = v_last ? '0 : vcount + VW'(1);
    end
    hblank_nxt = (hcount_nxt >= HW'(H_ACTIVE));
    vblank_nxt = (vcount_nxt >= VW'(V_ACTIVE));
    hsync_nxt  = ((hcount_nxt >= HW'(HS_START)) && (hcount_nxt < HW'(HS_END))) ? HS_POL : ~HS_POL;
    vsync_nxt  = ((vcount_nxt >= VW'(VS_START)) && (vcount_nxt < VW'(VS_END))) ? VS_POL : ~VS_POL;
  end

  // Raster state: divider, counters, decoded outputs, strobes, frame count and interrupt.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      div         <= '0;
      hcount      <= '0;
      vcount      <= '0;
      frame_cnt   <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      hblank      <= 1'b0;
      vblank      <= 1'b0;
      active      <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      vint        <= 1'b0;
    end else if (sync_rst) begin
      div         <= '0;
      hcount      <= '0;
      vcount      <= '0;
      frame_cnt   <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      hblank      <= 1'b0;
      vblank      <= 1'b0;
      active      <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      vint        <= 1'b0;
    end else begin
      // wrap_h/wrap_v are already gated by en, so strobes drop while frozen.
      line_start  <= wrap_h;
      frame_start <= wrap_v;
      if (en) begin
        div    <= div_nxt;
        hcount <= hcount_nxt;
        vcount <= vcount_nxt;
        hsync  <= hsync_nxt;
        vsync  <= vsync_nxt;
        hblank <= hblank_nxt;
        vblank <= vblank_nxt;
        active <= ~(hblank_nxt | vblank_nxt);
        if (wrap_v) begin
          frame_cnt <= frame_cnt + FW'(1);
        end
        // A set on the wrap edge takes priority over a simultaneous acknowledge.
        if (wrap_h && vint_en && (vcount_nxt == vint_line)) begin
          vint <= 1'b1;
        end else if (vint_ack) begin
          vint <= 1'b0;
        end
      end
    end
  end

endmodule
